// File: rtl/switch_pkg.sv
// Shared switch-fabric types: port indices and destination decode of a packet byte.
package switch_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [1:0] port_idx_t;

  localparam port_idx_t PORT_DROP = 2'd0;

  function automatic port_idx_t dest_of(logic [DATA_W-1:0] b);
    return b[DATA_W-1 -: 2];
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; priority starts just after the last winner and wraps 3 -> 1.
module rr_arbiter3
  import switch_pkg::*;
(
  input  logic [3:1] req_i,
  input  port_idx_t  last_i,
  output logic [3:1] grant_o,
  output port_idx_t  winner_o
);

  port_idx_t ord [3];
  logic      found;

  always_comb begin
    grant_o  = '0;
    winner_o = PORT_DROP;
    found    = 1'b0;
    case (last_i)
      2'd1: begin ord[0] = 2'd2; ord[1] = 2'd3; ord[2] = 2'd1; end
      2'd2: begin ord[0] = 2'd3; ord[1] = 2'd1; ord[2] = 2'd2; end
      default: begin ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd3; end
    endcase
    for (int n = 0; n < 3; n++) begin
      if (!found && req_i[ord[n]]) begin
        found             = 1'b1;
        grant_o[ord[n]]   = 1'b1;
        winner_o          = ord[n];
      end
    end
  end

endmodule

// File: rtl/crossbar_scheduler.sv
// 3x3 crossbar scheduler: stages one byte per ingress FIFO, drops dest-0 bytes and
// round-robin arbitrates each output port, registering data, source select and valid.
module crossbar_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  output logic              rdreq1,
  output logic              rdreq2,
  output logic              rdreq3,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic              out_valid3,
  output logic [1:0]        sel1,
  output logic [1:0]        sel2,
  output logic [1:0]        sel3,
  output logic [CNT_W-1:0]  drop_count
);
  import switch_pkg::*;

  logic [DATA_W-1:0] data_v     [1:3];
  logic [DATA_W-1:0] stage_q    [1:3];
  logic [DATA_W-1:0] stage_d    [1:3];
  logic [DATA_W-1:0] out_data_q [1:3];
  logic [DATA_W-1:0] out_data_d [1:3];
  port_idx_t         dest       [1:3];
  port_idx_t         winner     [1:3];
  port_idx_t         sel_q      [1:3];
  port_idx_t         sel_d      [1:3];
  port_idx_t         rr_last_q  [1:3];
  port_idx_t         rr_last_d  [1:3];
  logic [3:1]        req        [1:3];
  logic [3:1]        grant      [1:3];
  logic [3:1]        empty_v, rdreq, grant_in, drop;
  logic [3:1]        stage_v_q, stage_v_d, pend_q, out_valid_q, out_valid_d;
  logic [1:0]        n_drop;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  assign empty_v   = {empty3, empty2, empty1};
  assign data_v[1] = data1;
  assign data_v[2] = data2;
  assign data_v[3] = data3;

  always_comb begin
    for (int i = 1; i <= 3; i++) begin
      dest[i] = stage_q[i][DATA_W-1 -: 2];
      drop[i] = enable & stage_v_q[i] & (dest[i] == PORT_DROP);
    end
    for (int k = 1; k <= 3; k++) begin
      for (int i = 1; i <= 3; i++) begin
        req[k][i] = enable & stage_v_q[i] & (dest[i] == port_idx_t'(k));
      end
    end
  end

  for (genvar k = 1; k <= 3; k++) begin : g_arb
    rr_arbiter3 u_arb (
      .req_i    (req[k]),
      .last_i   (rr_last_q[k]),
      .grant_o  (grant[k]),
      .winner_o (winner[k])
    );
  end

  // A stage may be refilled in the same cycle it is granted.
  always_comb begin
    grant_in = grant[1] | grant[2] | grant[3];
    rdreq    = {3{reset_n & enable}} & ~empty_v & ~pend_q & (~stage_v_q | grant_in);
  end

  assign rdreq1 = rdreq[1];
  assign rdreq2 = rdreq[2];
  assign rdreq3 = rdreq[3];

  always_comb begin
    n_drop   = {1'b0, drop[1]} + {1'b0, drop[2]} + {1'b0, drop[3]};
    drop_sum = {1'b0, drop_count_q} + {{(CNT_W-1){1'b0}}, n_drop};
    drop_count_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    for (int i = 1; i <= 3; i++) begin
      stage_d[i]   = pend_q[i] ? data_v[i] : stage_q[i];
      stage_v_d[i] = pend_q[i] | (stage_v_q[i] & ~grant_in[i] & ~drop[i]);
    end
    for (int k = 1; k <= 3; k++) begin
      out_data_d[k]  = out_data_q[k];
      rr_last_d[k]   = rr_last_q[k];
      sel_d[k]       = PORT_DROP;
      out_valid_d[k] = 1'b0;
      if (|req[k]) begin
        out_data_d[k]  = stage_q[winner[k]];
        rr_last_d[k]   = winner[k];
        sel_d[k]       = winner[k];
        out_valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_v_q    <= '0;
      pend_q       <= '0;
      out_valid_q  <= '0;
      drop_count_q <= '0;
      for (int i = 1; i <= 3; i++) begin
        stage_q[i]    <= '0;
        out_data_q[i] <= '0;
        sel_q[i]      <= PORT_DROP;
        rr_last_q[i]  <= 2'd3;
      end
    end else begin
      stage_v_q    <= stage_v_d;
      pend_q       <= rdreq;
      out_valid_q  <= out_valid_d;
      drop_count_q <= drop_count_d;
      for (int i = 1; i <= 3; i++) begin
        stage_q[i]    <= stage_d[i];
        out_data_q[i] <= out_data_d[i];
        sel_q[i]      <= sel_d[i];
        rr_last_q[i]  <= rr_last_d[i];
      end
    end
  end

  assign out_data1  = out_data_q[1];
  assign out_data2  = out_data_q[2];
  assign out_data3  = out_data_q[3];
  assign out_valid1 = out_valid_q[1];
  assign out_valid2 = out_valid_q[2];
  assign out_valid3 = out_valid_q[3];
  assign sel1       = sel_q[1];
  assign sel2       = sel_q[2];
  assign sel3       = sel_q[3];
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler with a small behavioural model of the ingress FIFOs.
module tb_crossbar_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       empty    [1:3];
  logic [7:0] fdata    [1:3];
  logic       rdreq    [1:3];
  logic [7:0] out_data [1:3];
  logic       out_valid[1:3];
  logic [1:0] sel      [1:3];
  logic [15:0] drop_count;

  logic [7:0] mem [1:3][0:15];
  int wr_cnt [1:3];
  int rd_cnt [1:3];
  int checks = 0;
  int failures = 0;
  int exp_drops = 0;

  typedef struct {
    int         src;
    logic [7:0] b;
    int         port;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  assign empty[1] = (wr_cnt[1] == rd_cnt[1]);
  assign empty[2] = (wr_cnt[2] == rd_cnt[2]);
  assign empty[3] = (wr_cnt[3] == rd_cnt[3]);

  // FIFO read data appears the cycle after the pop request.
  always @(posedge clk) begin
    for (int i = 1; i <= 3; i++) begin
      if (rdreq[i]) begin
        fdata[i]  <= mem[i][rd_cnt[i] % 16];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  crossbar_scheduler #(.DATA_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .empty1     (empty[1]),
    .empty2     (empty[2]),
    .empty3     (empty[3]),
    .data1      (fdata[1]),
    .data2      (fdata[2]),
    .data3      (fdata[3]),
    .rdreq1     (rdreq[1]),
    .rdreq2     (rdreq[2]),
    .rdreq3     (rdreq[3]),
    .out_data1  (out_data[1]),
    .out_data2  (out_data[2]),
    .out_data3  (out_data[3]),
    .out_valid1 (out_valid[1]),
    .out_valid2 (out_valid[2]),
    .out_valid3 (out_valid[3]),
    .sel1       (sel[1]),
    .sel2       (sel[2]),
    .sel3       (sel[3]),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int s, input logic [7:0] b);
    mem[s][wr_cnt[s] % 16] = b;
    wr_cnt[s]++;
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("%s out_valid%0d", tag, k), int'(out_valid[k]), 0);
    end
  endtask

  task automatic chk_out(input string tag, input int k, input int b, input int s);
    chk($sformatf("%s out_valid%0d", tag, k), int'(out_valid[k]), 1);
    chk($sformatf("%s out_data%0d", tag, k), int'(out_data[k]), b);
    chk($sformatf("%s sel%0d", tag, k), int'(sel[k]), s);
  endtask

  initial begin
    vecs[0] = '{src: 1, b: 8'h8A, port: 2};
    vecs[1] = '{src: 2, b: 8'hC3, port: 3};
    vecs[2] = '{src: 1, b: 8'h3F, port: 0};
    vecs[3] = '{src: 2, b: 8'h66, port: 1};
    vecs[4] = '{src: 3, b: 8'h15, port: 0};
    vecs[5] = '{src: 3, b: 8'h55, port: 1};

    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("rst out_valid%0d", k), int'(out_valid[k]), 0);
      chk($sformatf("rst out_data%0d", k), int'(out_data[k]), 0);
      chk($sformatf("rst sel%0d", k), int'(sel[k]), 0);
    end
    chk("rst drop_count", int'(drop_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted while input 1 is streaming.
    push(1, 8'h41); push(1, 8'h42); push(1, 8'h43); push(1, 8'h44);
    repeat (3) tick();
    chk_out("pre-reset", 1, 8'h41, 1);
    reset_n = 1'b0;
    #1;
    chk_idle("in-reset");
    chk("in-reset out_data1", int'(out_data[1]), 0);
    chk("in-reset sel1", int'(sel[1]), 0);
    chk("in-reset rdreq1", int'(rdreq[1]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post-reset rdreq1", int'(rdreq[1]), 1);
    chk("post-reset rdreq2", int'(rdreq[2]), 0);
    repeat (10) tick();
    chk_idle("drained");

    // Single bytes through the fabric, one at a time.
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].src, vecs[v].b);
      #1;
      for (int i = 1; i <= 3; i++) begin
        chk($sformatf("v%0d rdreq%0d", v, i), int'(rdreq[i]), (i == vecs[v].src) ? 1 : 0);
      end
      tick();
      chk_idle($sformatf("v%0d t+1", v));
      tick();
      chk_idle($sformatf("v%0d t+2", v));
      tick();
      if (vecs[v].port == 0) begin
        exp_drops++;
        chk_idle($sformatf("v%0d drop", v));
      end else begin
        chk_out($sformatf("v%0d", v), vecs[v].port, int'(vecs[v].b), vecs[v].src);
      end
      chk($sformatf("v%0d drop_count", v), int'(drop_count), exp_drops);
      tick();
      chk_idle($sformatf("v%0d after", v));
    end

    // Three inputs contending for port 1.
    push(1, 8'h41); push(2, 8'h42); push(3, 8'h43);
    repeat (3) tick();
    chk_out("cont0", 1, 8'h41, 1);
    tick();
    chk_out("cont1", 1, 8'h42, 2);
    tick();
    chk_out("cont2", 1, 8'h43, 3);
    tick();
    chk_idle("cont end");
    push(2, 8'h47); push(1, 8'h46);
    repeat (3) tick();
    chk_out("round2 a", 1, 8'h46, 1);
    tick();
    chk_out("round2 b", 1, 8'h47, 2);
    tick();
    chk_idle("round2 end");

    // Disjoint destinations proceed in parallel.
    push(1, 8'hC1); push(2, 8'h41); push(3, 8'h81);
    repeat (3) tick();
    chk_out("par p1", 1, 8'h41, 2);
    chk_out("par p2", 2, 8'h81, 3);
    chk_out("par p3", 3, 8'hC1, 1);
    tick();
    chk_idle("par end");

    // Freeze with staged bytes, then release.
    push(1, 8'h81); push(2, 8'h82); push(3, 8'h83);
    tick();
    enable = 1'b0;
    push(1, 8'h84);
    #1;
    chk("frozen rdreq1", int'(rdreq[1]), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_idle($sformatf("frozen c%0d", c));
      chk($sformatf("frozen c%0d sel2", c), int'(sel[2]), 0);
    end
    enable = 1'b1;
    tick();
    chk_out("thaw0", 2, 8'h81, 1);
    tick();
    chk_out("thaw1", 2, 8'h82, 2);
    tick();
    chk_out("thaw2", 2, 8'h83, 3);
    tick();
    chk_out("thaw3", 2, 8'h84, 1);
    tick();
    chk_idle("thaw end");
    chk("final drop_count", int'(drop_count), exp_drops);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
